// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : Multi-port register file with write-to-read bypass and a
//            per-register pending scoreboard for decode-stage hazard checks.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter  int XLEN   = 8,
    parameter  int NREGS  = 8,
    parameter  int NREAD  = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*XLEN-1:0] rd,
    output logic [NREAD-1:0]      rd_pend,
    input  logic                  alloc_en,
    input  logic [AW-1:0]         alloc_addr,
    output logic                  alloc_stall,
    output logic [AW:0]           pend_cnt,
    input  logic [AW-1:0]         dbg_addr,
    output logic [XLEN-1:0]       dbg_data
);

    localparam logic C_BYPASS_EN = (BYPASS != 0);

    logic [NREGS-1:0][XLEN-1:0] regs_q;
    logic [NREGS-1:0][XLEN-1:0] regs_d;
    logic [NREGS-1:0]           pend_q;
    logic [NREGS-1:0]           pend_d;
    logic [AW:0]                pend_cnt_q;
    logic [AW:0]                pend_cnt_d;

    logic [NREGS-1:0]           w_wb_hit;
    logic                       w_alloc_ok;
    logic                       w_cnt_set;
    logic                       w_cnt_clr;

    always_comb begin
        for (int a = 0; a < NREGS; a++) begin
            w_wb_hit[a] = we && (waddr == AW'(a)) && (a != 0);
        end
    end

    assign alloc_stall = alloc_en & pend_q[alloc_addr] & ~w_wb_hit[alloc_addr];
    assign w_alloc_ok  = alloc_en & ~alloc_stall & (alloc_addr != '0);

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    // A same-edge allocation beats the writeback clear: the new producer owns the register.
    always_comb begin
        pend_d = pend_q;
        for (int a = 1; a < NREGS; a++) begin
            if (w_alloc_ok && (alloc_addr == AW'(a))) begin
                pend_d[a] = 1'b1;
            end else if (w_wb_hit[a]) begin
                pend_d[a] = 1'b0;
            end
        end
        pend_d[0] = 1'b0;
    end

    assign w_cnt_set = w_alloc_ok & ~pend_q[alloc_addr];
    assign w_cnt_clr = we & (waddr != '0) & pend_q[waddr]
                     & ~(w_alloc_ok & (alloc_addr == waddr));

    always_comb begin
        pend_cnt_d = pend_cnt_q;
        if (w_cnt_set && !w_cnt_clr) begin
            pend_cnt_d = pend_cnt_q + 1'b1;
        end else if (w_cnt_clr && !w_cnt_set) begin
            pend_cnt_d = pend_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q     <= '0;
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rd;

        assign w_ra = ra[i*AW +: AW];

        always_comb begin
            if (w_ra == '0) begin
                w_rd = '0;
            end else if (C_BYPASS_EN && we && (waddr == w_ra)) begin
                w_rd = wdata;
            end else begin
                w_rd = regs_q[w_ra];
            end
        end

        assign rd[i*XLEN +: XLEN] = w_rd;
        assign rd_pend[i]         = pend_q[w_ra] & ~(C_BYPASS_EN & w_wb_hit[w_ra]);
    end

    assign pend_cnt = pend_cnt_q;
    assign dbg_data = regs_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Brief    : Scoreboard bench for regfile_sb: directed checks on an 8x8 file
//            (bypass on and off) and a randomized 32x32x3 run against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8 regs x 8 bits, 2 read ports; instances a (bypass) and b (no bypass) share inputs
    logic        a_we = 0;
    logic [2:0]  a_waddr = 0;
    logic [7:0]  a_wdata = 0;
    logic [5:0]  a_ra = 0;
    logic [15:0] a_rd, b_rd;
    logic [1:0]  a_rd_pend, b_rd_pend;
    logic        a_alloc_en = 0;
    logic [2:0]  a_alloc_addr = 0;
    logic        a_alloc_stall, b_alloc_stall;
    logic [3:0]  a_pend_cnt, b_pend_cnt;
    logic [2:0]  a_dbg_addr = 0;
    logic [7:0]  a_dbg_data, b_dbg_data;

    logic        c_we = 0;
    logic [4:0]  c_waddr = 0;
    logic [31:0] c_wdata = 0;
    logic [14:0] c_ra = 0;
    logic [95:0] c_rd;
    logic [2:0]  c_rd_pend;
    logic        c_alloc_en = 0;
    logic [4:0]  c_alloc_addr = 0;
    logic        c_alloc_stall;
    logic [5:0]  c_pend_cnt;
    logic [4:0]  c_dbg_addr = 0;
    logic [31:0] c_dbg_data;

    regfile_sb #(.XLEN(8), .NREGS(8), .NREAD(2), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst(rst), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
        .ra(a_ra), .rd(a_rd), .rd_pend(a_rd_pend), .alloc_en(a_alloc_en),
        .alloc_addr(a_alloc_addr), .alloc_stall(a_alloc_stall),
        .pend_cnt(a_pend_cnt), .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data)
    );

    regfile_sb #(.XLEN(8), .NREGS(8), .NREAD(2), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst(rst), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
        .ra(a_ra), .rd(b_rd), .rd_pend(b_rd_pend), .alloc_en(a_alloc_en),
        .alloc_addr(a_alloc_addr), .alloc_stall(b_alloc_stall),
        .pend_cnt(b_pend_cnt), .dbg_addr(a_dbg_addr), .dbg_data(b_dbg_data)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(3), .BYPASS(1)) u_dut_c (
        .clk(clk), .rst(rst), .we(c_we), .waddr(c_waddr), .wdata(c_wdata),
        .ra(c_ra), .rd(c_rd), .rd_pend(c_rd_pend), .alloc_en(c_alloc_en),
        .alloc_addr(c_alloc_addr), .alloc_stall(c_alloc_stall),
        .pend_cnt(c_pend_cnt), .dbg_addr(c_dbg_addr), .dbg_data(c_dbg_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    string       tag_q[$];
    int          sel_q[$];
    logic [31:0] exp_q[$];

    localparam int S_A_RD0 = 0, S_A_RD1 = 1, S_A_PEND = 2, S_A_STALL = 3, S_A_CNT = 4,
                   S_A_DBG = 5, S_B_RD0 = 6, S_B_RD1 = 7, S_B_PEND = 8, S_C_RD = 10,
                   S_C_PEND = 13, S_C_STALL = 14, S_C_CNT = 15, S_C_DBG = 16;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_A_RD0:   return {24'd0, a_rd[7:0]};
            S_A_RD1:   return {24'd0, a_rd[15:8]};
            S_A_PEND:  return {30'd0, a_rd_pend};
            S_A_STALL: return {31'd0, a_alloc_stall};
            S_A_CNT:   return {28'd0, a_pend_cnt};
            S_A_DBG:   return {24'd0, a_dbg_data};
            S_B_RD0:   return {24'd0, b_rd[7:0]};
            S_B_RD1:   return {24'd0, b_rd[15:8]};
            S_B_PEND:  return {30'd0, b_rd_pend};
            10, 11, 12: return c_rd[(sel-10)*32 +: 32];
            S_C_PEND:  return {29'd0, c_rd_pend};
            S_C_STALL: return {31'd0, c_alloc_stall};
            S_C_CNT:   return {26'd0, c_pend_cnt};
            S_C_DBG:   return c_dbg_data;
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(exp);
    endtask

    // Outputs are compared at the falling edge, then the rising edge commits the cycle.
    task automatic settle();
        @(negedge clk);
        while (sel_q.size() > 0) begin
            string       t;
            int          s;
            logic [31:0] e;
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            check_eq(t, obs(s), e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                           input logic [2:0] r0, input logic [2:0] r1,
                           input logic ae, input logic [2:0] aa, input logic [2:0] da);
        a_we = we; a_waddr = wa; a_wdata = wd;
        a_ra = {r1, r0};
        a_alloc_en = ae; a_alloc_addr = aa; a_dbg_addr = da;
    endtask

    logic [31:0] m_regs [32];
    bit          m_pend [32];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        drive_a(0, 0, 8'h00, 0, 0, 0, 0, 0);
        push("reset_rd0", S_A_RD0, 0); push("reset_rd1", S_A_RD1, 0);
        push("reset_pend", S_A_PEND, 0); push("reset_stall", S_A_STALL, 0);
        push("reset_cnt", S_A_CNT, 0); push("reset_dbg", S_A_DBG, 0);
        settle();

        drive_a(1, 3, 8'hA5, 3, 0, 0, 0, 3);
        push("bypass_rd0", S_A_RD0, 8'hA5); push("nobypass_rd0", S_B_RD0, 8'h00);
        push("dbg_nobypass", S_A_DBG, 8'h00);
        settle();
        drive_a(0, 0, 8'h00, 3, 0, 0, 0, 3);
        push("readback_rd0", S_A_RD0, 8'hA5); push("readback_b_rd0", S_B_RD0, 8'hA5);
        push("readback_dbg", S_A_DBG, 8'hA5);
        settle();

        drive_a(1, 0, 8'hFF, 0, 0, 0, 0, 0);
        push("r0_write_rd0", S_A_RD0, 0); push("r0_write_rd1", S_A_RD1, 0);
        settle();
        drive_a(0, 0, 8'h00, 0, 0, 1, 0, 0);
        push("r0_read_rd0", S_A_RD0, 0); push("r0_read_rd1", S_A_RD1, 0);
        push("alloc0_stall", S_A_STALL, 0);
        settle();
        drive_a(0, 0, 8'h00, 0, 0, 0, 0, 0);
        push("alloc0_cnt", S_A_CNT, 0);
        settle();

        drive_a(0, 0, 8'h00, 3, 5, 1, 5, 0);
        push("alloc5_pend", S_A_PEND, 0); push("alloc5_stall", S_A_STALL, 0);
        push("alloc5_cnt", S_A_CNT, 0);
        settle();
        drive_a(0, 0, 8'h00, 3, 5, 1, 5, 0);
        push("waw_pend", S_A_PEND, 2'b10); push("waw_stall", S_A_STALL, 1);
        push("waw_cnt", S_A_CNT, 1);
        settle();
        drive_a(1, 5, 8'h3C, 3, 5, 1, 5, 0);
        push("wb5_pend", S_A_PEND, 0); push("wb5_rd1", S_A_RD1, 8'h3C);
        push("wb5_realloc_stall", S_A_STALL, 0); push("wb5_cnt", S_A_CNT, 1);
        push("wb5_b_pend", S_B_PEND, 2'b10); push("wb5_b_rd1", S_B_RD1, 8'h00);
        settle();
        drive_a(0, 0, 8'h00, 3, 5, 0, 0, 5);
        push("realloc_pend", S_A_PEND, 2'b10); push("realloc_cnt", S_A_CNT, 1);
        push("realloc_rd1", S_A_RD1, 8'h3C); push("realloc_dbg", S_A_DBG, 8'h3C);
        settle();
        drive_a(1, 5, 8'h3C, 0, 0, 0, 0, 0);
        settle();
        drive_a(0, 0, 8'h00, 0, 5, 0, 0, 0);
        push("clr5_cnt", S_A_CNT, 0); push("clr5_pend", S_A_PEND, 0);
        settle();

        drive_a(0, 0, 8'h00, 0, 0, 1, 2, 0);
        push("alloc2_cnt", S_A_CNT, 0);
        settle();
        drive_a(0, 0, 8'h00, 0, 0, 1, 6, 0);
        push("alloc6_cnt", S_A_CNT, 1);
        settle();
        drive_a(1, 2, 8'h22, 0, 0, 1, 7, 0);
        push("alloc7_wb2_cnt", S_A_CNT, 2); push("alloc7_stall", S_A_STALL, 0);
        settle();
        drive_a(0, 0, 8'h00, 6, 7, 0, 0, 0);
        push("net0_cnt", S_A_CNT, 2); push("pend_r6_r7", S_A_PEND, 2'b11);
        settle();
        drive_a(0, 0, 8'h00, 2, 5, 0, 0, 0);
        push("pend_r2_r5", S_A_PEND, 0); push("r2_data", S_A_RD0, 8'h22);
        settle();

        drive_a(0, 0, 8'h00, 0, 0, 1, 1, 0);
        push("alloc1_cnt", S_A_CNT, 2);
        settle();
        drive_a(0, 0, 8'h00, 0, 0, 1, 4, 0);
        push("alloc4_cnt", S_A_CNT, 3);
        settle();
        drive_a(1, 4, 8'h11, 4, 0, 0, 0, 0);
        push("wb4_cnt", S_A_CNT, 4); push("wb4_rd0", S_A_RD0, 8'h11);
        push("wb4_pend", S_A_PEND, 0);
        settle();
        drive_a(0, 0, 8'h00, 0, 0, 0, 0, 0);
        push("after_wb4_cnt", S_A_CNT, 3);
        settle();
        rst = 1'b1;
        drive_a(1, 1, 8'h99, 0, 0, 1, 3, 0);
        settle();
        rst = 1'b0;
        drive_a(0, 0, 8'h00, 4, 1, 0, 0, 4);
        push("rst_rd0", S_A_RD0, 0); push("rst_rd1", S_A_RD1, 0);
        push("rst_pend", S_A_PEND, 0); push("rst_cnt", S_A_CNT, 0);
        push("rst_dbg4", S_A_DBG, 0); push("rst_stall", S_A_STALL, 0);
        settle();
        drive_a(0, 0, 8'h00, 3, 6, 0, 0, 3);
        push("rst_r3", S_A_RD0, 0); push("rst_r6", S_A_RD1, 0);
        push("rst_dbg3", S_A_DBG, 0); push("rst_pend36", S_A_PEND, 0);
        settle();
        drive_a(1, 1, 8'h77, 1, 0, 0, 0, 0);
        push("postrst_wb1_rd0", S_A_RD0, 8'h77); push("postrst_wb1_pend", S_A_PEND, 0);
        push("postrst_wb1_cnt", S_A_CNT, 0);
        settle();
        drive_a(0, 0, 8'h00, 1, 0, 0, 0, 0);
        push("postrst_cnt", S_A_CNT, 0); push("postrst_r1", S_A_RD0, 8'h77);
        settle();

        // Randomized phase on the 32x32x3 instance against a behavioural model.
        for (int k = 0; k < 32; k++) begin
            m_regs[k] = '0;
            m_pend[k] = 1'b0;
        end
        rst = 1'b1;
        settle();
        rst = 1'b0;
        for (int n = 0; n < 500; n++) begin
            logic [4:0]  ra_v [3];
            logic [31:0] erd;
            logic [2:0]  epend;
            logic        estall;
            logic        ok;
            int          cnt;

            c_we    = 1'($urandom_range(0, 1));
            c_waddr = 5'($urandom_range(0, 31));
            c_wdata = $urandom;
            for (int i = 0; i < 3; i++) begin
                ra_v[i] = ($urandom_range(0, 3) == 0) ? c_waddr : 5'($urandom_range(0, 31));
                c_ra[i*5 +: 5] = ra_v[i];
            end
            c_alloc_en   = 1'($urandom_range(0, 1));
            c_alloc_addr = ($urandom_range(0, 3) == 0) ? c_waddr : 5'($urandom_range(0, 31));
            c_dbg_addr   = 5'($urandom_range(0, 31));
            rst          = ($urandom_range(0, 63) == 0);

            for (int i = 0; i < 3; i++) begin
                if (ra_v[i] == 0)                     erd = 0;
                else if (c_we && c_waddr == ra_v[i])  erd = c_wdata;
                else                                  erd = m_regs[ra_v[i]];
                push($sformatf("rnd_rd%0d", i), S_C_RD + i, erd);
                epend[i] = m_pend[ra_v[i]] && !(c_we && c_waddr == ra_v[i] && ra_v[i] != 0);
            end
            estall = c_alloc_en && m_pend[c_alloc_addr]
                   && !(c_we && c_waddr == c_alloc_addr && c_alloc_addr != 0);
            cnt = 0;
            for (int k = 0; k < 32; k++) cnt += int'(m_pend[k]);
            push("rnd_pend", S_C_PEND, {29'd0, epend});
            push("rnd_stall", S_C_STALL, {31'd0, estall});
            push("rnd_cnt", S_C_CNT, cnt);
            push("rnd_dbg", S_C_DBG, m_regs[c_dbg_addr]);
            settle();

            if (rst) begin
                for (int k = 0; k < 32; k++) begin
                    m_regs[k] = '0;
                    m_pend[k] = 1'b0;
                end
            end else begin
                ok = c_alloc_en && !estall && c_alloc_addr != 0;
                if (c_we && c_waddr != 0) begin
                    m_regs[c_waddr] = c_wdata;
                    m_pend[c_waddr] = 1'b0;
                end
                if (ok) m_pend[c_alloc_addr] = 1'b1;
            end
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-port register file with write-to-read bypass and a per-register pending scoreboard, for the pipelined core's decode stage. Width, depth and read-port count are generalised. Register 0 is hardwired to zero. The scoreboard tracks in-flight producers so that decode can detect RAW hazards and stall on WAW hazards. A single debug read port replaces the old per-register dump outputs.

Parameters:
XLEN, 8, data width in bits
NREGS, 8, number of registers; power of two, at least 2
NREAD, 2, number of read ports, 1..4
BYPASS, 1, 1 forwards same-cycle write data to read ports; 0 disables forwarding
AW, clog2(NREGS), address width; derived localparam, not overridable

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
we  in  1  writeback enable
waddr  in  AW  writeback register address
wdata  in  XLEN  writeback data
ra  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW]
rd  out  NREAD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
rd_pend  out  NREAD  per-port flag: source register still has an in-flight producer
alloc_en  in  1  decode issues an instruction that will write alloc_addr
alloc_addr  in  AW  destination register being allocated
alloc_stall  out  1  allocation refused (WAW hazard); decode must hold
pend_cnt  out  AW+1  number of registers currently pending
dbg_addr  in  AW  debug read address
dbg_data  out  XLEN  debug read data, no bypass

Behaviour:
Reset and clocking:
- One clock `clk`. Reset is synchronous and active-high.
- `rst` high at a rising edge clears all registers to 0, clears all pending bits, and sets pend_cnt to 0. `rst` overrides any same-cycle write or alloc.
- After reset all outputs are combinationally 0: rd = 0, rd_pend = 0, alloc_stall = 0, pend_cnt = 0, dbg_data = 0.

Writes:
- On a rising edge with we=1 and waddr≠0, regs[waddr] ← wdata.
- A write to address 0 is ignored; regs[0] always reads 0.

Reads (combinational, zero latency):
- If ra_i=0, rd_i = 0.
- Else if BYPASS=1 and we=1 and waddr=ra_i, rd_i = wdata.
- Otherwise rd_i = regs[ra_i].
- dbg_data = regs[dbg_addr]; never bypassed.

Scoreboard, pend[NREGS-1:0]:
- pend[0] is constant 0.
- Let wb_hit(a) = we & (waddr=a) & (a≠0).
- rd_pend_i = pend[ra_i] & ~(BYPASS & wb_hit(ra_i)).
- alloc_stall = alloc_en & pend[alloc_addr] & ~wb_hit(alloc_addr).
- alloc_ok = alloc_en & ~alloc_stall & (alloc_addr≠0).

Scoreboard update at each rising edge, per register a≠0:
- alloc_ok and alloc_addr=a: pend[a] ← 1. This holds even if wb_hit(a) in the same cycle; the new producer wins.
- Else wb_hit(a): pend[a] ← 0.
- Otherwise pend[a] holds.
- A writeback to a non-pending register is legal: data is written and pend is unchanged.

pend_cnt:
- Registered count of set pend bits, updated every edge by +1, −1 or 0 according to that edge's set and clear events.
- It never exceeds NREGS−1 and never underflows.
- An alloc and a clear of different registers on the same edge net to 0.

Other rules:
- alloc_en with alloc_addr=0 does nothing and does not stall.
- Reset asserted mid-operation (pending entries outstanding) drops all pending state; later writebacks to those registers are treated as plain writes.

Test Plan:
- Reset, then write r3=0xA5 and read it back on port 0 in the next cycle → rd0 = 0xA5. In the write cycle with ra0=3 and BYPASS=1 → rd0 = 0xA5 (bypass). With BYPASS=0, the write cycle shows the old value 0x00.
- Write r0=0xFF, then read ra0=0 and ra1=0 → both read 0x00; pend_cnt stays 0 after alloc_addr=0.
- Alloc r5, then read ra1=5 → rd_pend[1]=1, pend_cnt=1. A second alloc of r5 → alloc_stall=1 and pend_cnt stays 1. Writeback r5=0x3C → in that cycle rd_pend[1]=0, rd1=0x3C, and a second alloc r5 in the same cycle is accepted with pend[5] remaining 1.
- Alloc r2 and r6 on consecutive edges, then in one cycle alloc r7 with writeback r2 → pend_cnt goes 1, 2, 2; pend = {r6, r7}.
- Alloc r1 and r4, write r4=0x11, then assert rst for one edge → all regs read 0, rd_pend=0, pend_cnt=0, dbg_data for r4 reads 0. A following writeback to r1 leaves pend_cnt at 0.
- NREGS=32, XLEN=32, NREAD=3: random writes and allocs checked against a reference model → rd, rd_pend, pend_cnt and alloc_stall match the model every cycle.
